// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Instruction fetch front end. Owns the program counter, presents
//            it to a combinational-read instruction memory, latches the
//            returned word into a fetch register and hands it to decode over
//            a valid/ready handshake. Services branch redirects (flush plus
//            new PC) and stops fetching on the halt opcode.
// Ports    : clock, reset_n         - clock / async active-low reset
//            run                    - fetch enable (level)
//            imem_address           - current PC to instruction memory
//            imem_instruction       - memory read data (same cycle)
//            out_valid/out_ready    - handshake to decode
//            out_instruction/out_pc - fetched word and its address
//            branch_taken/target    - one-cycle redirect request
//            halted                 - sequencer is halted
//            addr_error             - sticky, redirect target out of range
//            fetch_count/stall_count- perf counters (FETCH_PERF_EN only)
// Options  : `define FETCH_PERF_EN adds saturating fetch/stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter int         ADDR_WIDTH  = 10,
    parameter int         INSTR_WIDTH = 10,
    parameter int         LAST_ADDR   = 32,
    parameter logic [2:0] HALT_OPCODE = 3'b111
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   run,
    output logic [ADDR_WIDTH-1:0]  imem_address,
    input  logic [INSTR_WIDTH-1:0] imem_instruction,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] out_instruction,
    output logic [ADDR_WIDTH-1:0]  out_pc,
    input  logic                   branch_taken,
    input  logic [ADDR_WIDTH-1:0]  branch_target,
    output logic                   halted,
    output logic                   addr_error
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]            fetch_count,
    output logic [15:0]            stall_count
`endif
);

    localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(LAST_ADDR);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [ADDR_WIDTH-1:0]  r_pc;
    logic [ADDR_WIDTH-1:0]  w_pc_next;
    logic                   r_valid;
    logic                   w_valid_next;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic [INSTR_WIDTH-1:0] w_instr_next;
    logic [ADDR_WIDTH-1:0]  r_out_pc;
    logic [ADDR_WIDTH-1:0]  w_out_pc_next;
    logic                   r_addr_error;
    logic                   w_addr_error_next;

    logic                   w_redirect;
    logic                   w_target_bad;
    logic                   w_is_halt;
    logic                   w_advance;
    logic [ADDR_WIDTH-1:0]  w_pc_inc;

    // Redirects are ignored until the sequencer has left IDLE.
    assign w_redirect   = branch_taken && (r_state != ST_IDLE);
    assign w_target_bad = branch_target > c_last_addr;
    assign w_is_halt    = imem_instruction[INSTR_WIDTH-1 -: 3] == HALT_OPCODE;
    // A redirect in the same cycle pre-empts the fetch.
    assign w_advance    = (r_state == ST_FETCH) && !branch_taken && run
                          && (!r_valid || out_ready);
    assign w_pc_inc     = (r_pc == c_last_addr) ? '0 : r_pc + ADDR_WIDTH'(1);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_pc         <= '0;
            r_valid      <= 1'b0;
            r_instr      <= '0;
            r_out_pc     <= '0;
            r_addr_error <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_pc         <= w_pc_next;
            r_valid      <= w_valid_next;
            r_instr      <= w_instr_next;
            r_out_pc     <= w_out_pc_next;
            r_addr_error <= w_addr_error_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state / datapath control
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next      = r_state;
        w_pc_next         = r_pc;
        w_valid_next      = r_valid;
        w_instr_next      = r_instr;
        w_out_pc_next     = r_out_pc;
        w_addr_error_next = r_addr_error;

        case (r_state)
            ST_IDLE: begin
                // The transition cycle itself performs no fetch.
                if (run) begin
                    w_state_next = ST_FETCH;
                end
            end

            ST_FETCH, ST_HALTED: begin
                if (w_redirect) begin
                    // Flush regardless of out_ready.
                    w_valid_next = 1'b0;
                    if (w_target_bad) begin
                        w_addr_error_next = 1'b1;
                        w_state_next      = ST_HALTED;
                    end else begin
                        w_pc_next    = branch_target;
                        w_state_next = ST_FETCH;
                    end
                end else if (w_advance) begin
                    w_instr_next  = imem_instruction;
                    w_out_pc_next = r_pc;
                    w_valid_next  = 1'b1;
                    if (w_is_halt) begin
                        // Halt word is still delivered; PC parks on it.
                        w_state_next = ST_HALTED;
                    end else begin
                        w_pc_next = w_pc_inc;
                    end
                end else if (out_ready && (r_state == ST_HALTED || !run)) begin
                    // Drain the fetch register when no new word replaces it.
                    w_valid_next = 1'b0;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign imem_address    = r_pc;
    assign out_valid       = r_valid;
    assign out_instruction = r_instr;
    assign out_pc          = r_out_pc;
    assign halted          = (r_state == ST_HALTED);
    assign addr_error      = r_addr_error;

`ifdef FETCH_PERF_EN
    // ------------------------------------------------------------------------
    // Saturating performance counters; only FETCH-state activity is counted.
    // ------------------------------------------------------------------------
    logic [15:0] r_fetch_count;
    logic [15:0] r_stall_count;
    logic        w_stall;

    assign w_stall = (r_state == ST_FETCH) && run && r_valid && !out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_advance && (r_fetch_count != 16'hFFFF)) begin
                r_fetch_count <= r_fetch_count + 16'd1;
            end
            if (w_stall && (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    assign fetch_count = r_fetch_count;
    assign stall_count = r_stall_count;
`endif

endmodule
`default_nettype wire
